// File: rtl/life_pkg.sv
// Shared constants and helpers for the Game of Life generation engine.
package life_pkg;

    localparam int NBR_W = 4;
    localparam logic [NBR_W-1:0] LIFE_BIRTH   = 4'd3;
    localparam logic [NBR_W-1:0] LIFE_SURVIVE = 4'd2;

    typedef logic [15:0] gen_cnt_t;

    // Masking wraps -1 and X/Y back into range, giving the torus topology.
    function automatic int life_idx(input int x, input int y, input int log2x, input int log2y);
        int xw;
        int yw;
        xw = x & ((1 << log2x) - 1);
        yw = y & ((1 << log2y) - 1);
        return (yw << log2x) | xw;
    endfunction

endpackage

// File: rtl/life_if.sv
// Scan, seed and status signals between the scan counter side and life_gen.
interface life_if #(
    parameter int LOG2X = 3,
    parameter int LOG2Y = 3
);
    localparam int AW = LOG2X + LOG2Y;

    logic [AW-1:0] cnt;
    logic          nxt_bit;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic          load_data;
    logic          clear;
    logic          cell_out;
    logic          gen_done;
    logic [15:0]   gen_cnt;
    logic [AW:0]   pop_cnt;

    modport master (
        output cnt, nxt_bit, load_en, load_addr, load_data, clear,
        input  cell_out, gen_done, gen_cnt, pop_cnt
    );

    modport slave (
        input  cnt, nxt_bit, load_en, load_addr, load_data, clear,
        output cell_out, gen_done, gen_cnt, pop_cnt
    );

endinterface

// File: rtl/life_nbr.sv
// Combinational neighbour sum and next-state rule for one cell of a toroidal grid.
module life_nbr
    import life_pkg::*;
#(
    parameter int X     = 8,
    parameter int Y     = 8,
    parameter int LOG2X = 3,
    parameter int LOG2Y = 3
) (
    input  logic [X*Y-1:0]         grid_i,
    input  logic [LOG2X+LOG2Y-1:0] k_i,
    output logic [NBR_W-1:0]       sum_o,
    output logic                   nxt_o
);
    localparam int AW = LOG2X + LOG2Y;

    int xk;
    int yk;

    assign xk = int'(k_i[LOG2X-1:0]);
    assign yk = int'(k_i[AW-1:LOG2X]);

    always_comb begin
        sum_o = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (dx != 0 || dy != 0) begin
                    sum_o = sum_o + NBR_W'(grid_i[AW'(life_idx(xk + dx, yk + dy, LOG2X, LOG2Y))]);
                end
            end
        end
    end

    assign nxt_o = (sum_o == LIFE_BIRTH) | (grid_i[k_i] & (sum_o == LIFE_SURVIVE));

endmodule

// File: rtl/life_gen.sv
// Game of Life generation engine: serves the current grid one cell per clock and
// computes the next generation serially across one scan frame when stepping.
module life_gen
    import life_pkg::*;
#(
    parameter int X     = 8,
    parameter int Y     = 8,
    parameter int LOG2X = 3,
    parameter int LOG2Y = 3
) (
    input  logic clk,
    input  logic reset,
    life_if.slave bus
);
    localparam int N  = X * Y;
    localparam int AW = LOG2X + LOG2Y;
    localparam int PW = AW + 1;

    logic [N-1:0]     cur_grid_q, cur_grid_d;
    logic [N-1:0]     nxt_grid_q, nxt_grid_d;
    logic             active_q, active_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    pop_cnt_q, pop_cnt_d;
    gen_cnt_t         gen_cnt_q, gen_cnt_d;
    logic             gen_done_q, gen_done_d;
    logic             cell_out_q;

    logic [NBR_W-1:0] nbr_sum;
    logic             new_bit;
    logic             frame_start;
    logic             frame_end;
    logic             act;
    logic             unused_nbr_sum;

    life_nbr #(
        .X    (X),
        .Y    (Y),
        .LOG2X(LOG2X),
        .LOG2Y(LOG2Y)
    ) u_nbr (
        .grid_i(cur_grid_q),
        .k_i   (bus.cnt),
        .sum_o (nbr_sum),
        .nxt_o (new_bit)
    );

    assign unused_nbr_sum = ^nbr_sum;

    assign frame_start = (bus.cnt == '0);
    assign frame_end   = (bus.cnt == AW'(N - 1));
    // The frame's step decision is taken from nxt_bit in the cnt==0 cycle itself,
    // so cell 0 is computed in the same frame as the rest.
    assign act         = frame_start ? bus.nxt_bit : active_q;

    always_comb begin
        cur_grid_d = cur_grid_q;
        nxt_grid_d = nxt_grid_q;
        active_d   = active_q;
        acc_d      = acc_q;
        pop_cnt_d  = pop_cnt_q;
        gen_cnt_d  = gen_cnt_q;
        gen_done_d = 1'b0;

        if (bus.clear) begin
            cur_grid_d = '0;
            nxt_grid_d = '0;
            active_d   = 1'b0;
            acc_d      = '0;
            pop_cnt_d  = '0;
        end else begin
            if (frame_start) begin
                active_d = bus.nxt_bit;
            end
            if (act) begin
                nxt_grid_d[bus.cnt] = new_bit;
                acc_d = (frame_start ? '0 : acc_q) + PW'(new_bit);
                if (frame_end) begin
                    cur_grid_d = {new_bit, nxt_grid_q[N-2:0]};
                    pop_cnt_d  = acc_q + PW'(new_bit);
                    gen_cnt_d  = gen_cnt_q + 16'd1;
                    gen_done_d = 1'b1;
                end
            end else begin
                if (frame_start) begin
                    acc_d = '0;
                end
                if (bus.load_en) begin
                    cur_grid_d[bus.load_addr] = bus.load_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_grid_q <= '0;
            nxt_grid_q <= '0;
            active_q   <= 1'b0;
            acc_q      <= '0;
            pop_cnt_q  <= '0;
            gen_cnt_q  <= '0;
            gen_done_q <= 1'b0;
            cell_out_q <= 1'b0;
        end else begin
            cur_grid_q <= cur_grid_d;
            nxt_grid_q <= nxt_grid_d;
            active_q   <= active_d;
            acc_q      <= acc_d;
            pop_cnt_q  <= pop_cnt_d;
            gen_cnt_q  <= gen_cnt_d;
            gen_done_q <= gen_done_d;
            cell_out_q <= cur_grid_q[bus.cnt];
        end
    end

    assign bus.cell_out = cell_out_q;
    assign bus.gen_done = gen_done_q;
    assign bus.gen_cnt  = gen_cnt_q;
    assign bus.pop_cnt  = pop_cnt_q;

endmodule

// File: tb/tb_life_gen.sv
// Scoreboard bench for life_gen on the default 8x8 torus.
module tb_life_gen;

    localparam int N = 64;

    localparam logic [63:0] G_BLINK_V = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
    localparam logic [63:0] G_BLINK_H = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
    localparam logic [63:0] G_BLOCK   = (64'd1 << 0) | (64'd1 << 1) | (64'd1 << 8) | (64'd1 << 9);
    localparam logic [63:0] G_GLIDER  = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) |
                                        (64'd1 << 17) | (64'd1 << 18);

    typedef struct {
        bit          is_gen;
        bit          chk_grid;
        logic [63:0] grid;
        int          pop;
        int          gcnt;
    } sb_t;

    logic clk;
    logic reset;
    life_if #(.LOG2X(3), .LOG2Y(3)) bus ();

    life_gen #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    sb_t         sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_gen  = 0;
    bit          capturing = 0;
    logic [63:0] cap_grid;
    logic [63:0] exp_grid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_gen(input logic [63:0] g, input int pop, input bit chk);
        sb_t it;
        exp_gen++;
        it.is_gen = 1; it.chk_grid = chk; it.grid = g; it.pop = pop; it.gcnt = exp_gen;
        sb_q.push_back(it);
    endtask

    task automatic push_disp(input logic [63:0] g);
        sb_t it;
        it.is_gen = 0; it.chk_grid = 1; it.grid = g; it.pop = 0; it.gcnt = 0;
        sb_q.push_back(it);
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Scan counter model: free-running index, updated just after each rising edge.
    initial begin
        bus.cnt = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.cnt = bus.cnt + 1'b1;
        end
    end

    // Monitor: compares commits against queued expectations and captures display frames.
    initial begin
        bit  prev_gd;
        int  idx;
        sb_t it;
        prev_gd = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                capturing = 0;
                prev_gd   = 0;
            end else begin
                if (capturing) begin
                    idx = (int'(bus.cnt) + N - 1) % N;
                    cap_grid[idx] = bus.cell_out;
                    if (idx == N - 1) begin
                        check("grid", cap_grid, exp_grid);
                        capturing = 0;
                    end
                end
                if (bus.gen_done) begin
                    check("gen_done_pulse", 64'(prev_gd), 64'd0);
                    if (sb_q.size() == 0 || !sb_q[0].is_gen) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_gen_done: actual gen_cnt %0d, required no commit", bus.gen_cnt);
                    end else begin
                        it = sb_q.pop_front();
                        check("gen_cnt", 64'(bus.gen_cnt), 64'(it.gcnt));
                        check("pop_cnt", 64'(bus.pop_cnt), 64'(it.pop));
                        if (it.chk_grid) begin
                            exp_grid  = it.grid;
                            capturing = 1;
                        end
                    end
                end else if (!capturing && sb_q.size() != 0 && !sb_q[0].is_gen && bus.cnt == '0) begin
                    it = sb_q.pop_front();
                    exp_grid  = it.grid;
                    capturing = 1;
                end
                prev_gd = bus.gen_done;
            end
        end
    end

    task automatic wait_cnt(input int v);
        int t = 0;
        do begin
            @(posedge clk);
            #2;
            t++;
        end while (int'(bus.cnt) != v && t < 200);
        if (int'(bus.cnt) != v) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_cnt_timeout: actual %0d required %0d", bus.cnt, v);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb_q.size() != 0 || capturing) && t < 6000) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0 || capturing) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: actual %0d pending, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic load(input int addr, input logic data);
        bus.load_en   = 1;
        bus.load_addr = 6'(addr);
        bus.load_data = data;
        @(posedge clk);
        #2;
        bus.load_en = 0;
    endtask

    task automatic seed(input logic [63:0] g);
        for (int i = 0; i < N; i++) begin
            if (g[i]) load(i, 1'b1);
        end
    endtask

    task automatic pulse_clear();
        bus.clear = 1;
        @(posedge clk);
        #2;
        bus.clear = 0;
    endtask

    task automatic steps(input int n);
        wait_cnt(63);
        bus.nxt_bit = 1;
        repeat (n) wait_cnt(63);
        bus.nxt_bit = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] gen_before;
        reset         = 0;
        bus.nxt_bit   = 0;
        bus.load_en   = 0;
        bus.load_addr = '0;
        bus.load_data = 0;
        bus.clear     = 0;
        #22;
        check("rst_cell_out", 64'(bus.cell_out), 64'd0);
        check("rst_gen_done", 64'(bus.gen_done), 64'd0);
        check("rst_gen_cnt",  64'(bus.gen_cnt),  64'd0);
        check("rst_pop_cnt",  64'(bus.pop_cnt),  64'd0);
        reset = 1;
        repeat (3) @(posedge clk);
        #2;

        // Blinker oscillates vertical -> horizontal -> vertical.
        seed(G_BLINK_V);
        push_disp(G_BLINK_V);
        wait_idle();
        push_gen(G_BLINK_H, 3, 1);
        steps(1);
        wait_idle();
        push_gen(G_BLINK_V, 3, 1);
        steps(1);
        wait_idle();

        pulse_clear();
        check("idle_clear_pop", 64'(bus.pop_cnt), 64'd0);

        // Still-life block over five consecutive steps.
        seed(G_BLOCK);
        for (int i = 0; i < 5; i++) push_gen(G_BLOCK, 4, 1);
        steps(5);
        wait_idle();
        pulse_clear();

        // Glider returns to its starting cells after 32 generations on the torus.
        seed(G_GLIDER);
        for (int i = 0; i < 32; i++) push_gen(G_GLIDER, 5, i == 31);
        steps(32);
        wait_idle();
        pulse_clear();

        // Seed write during an active frame is dropped.
        seed(G_BLOCK);
        push_gen(G_BLOCK, 4, 1);
        wait_cnt(63);
        bus.nxt_bit = 1;
        wait_cnt(10);
        load(5, 1'b1);
        wait_cnt(63);
        bus.nxt_bit = 0;
        wait_idle();

        // Same write in an idle frame lands.
        wait_cnt(20);
        load(5, 1'b1);
        wait_cnt(6);
        check("idle_load_cell5", 64'(bus.cell_out), 64'd1);
        push_disp(G_BLOCK | (64'd1 << 5));
        wait_idle();

        // Clear mid-generation aborts the commit.
        gen_before = bus.gen_cnt;
        wait_cnt(63);
        bus.nxt_bit = 1;
        wait_cnt(30);
        bus.nxt_bit = 0;
        pulse_clear();
        push_disp(64'd0);
        wait_idle();
        check("clear_gen_cnt", 64'(bus.gen_cnt), 64'(gen_before));
        check("clear_gen_expected", 64'(bus.gen_cnt), 64'(exp_gen));
        check("clear_pop_cnt", 64'(bus.pop_cnt), 64'd0);

        // Asynchronous reset mid-frame.
        seed(G_BLINK_V);
        push_gen(G_BLINK_H, 3, 1);
        steps(1);
        wait_idle();
        wait_cnt(40);
        #1;
        reset = 0;
        #1;
        check("arst_cell_out", 64'(bus.cell_out), 64'd0);
        check("arst_gen_done", 64'(bus.gen_done), 64'd0);
        check("arst_gen_cnt",  64'(bus.gen_cnt),  64'd0);
        check("arst_pop_cnt",  64'(bus.pop_cnt),  64'd0);
        repeat (2) @(posedge clk);
        #2;
        reset   = 1;
        exp_gen = 0;
        seed(G_BLINK_V);
        push_disp(G_BLINK_V);
        wait_idle();
        push_gen(G_BLINK_H, 3, 1);
        steps(1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
